cam_ctrl: RTL and testbench

CAM_CTRL -- requirements
Module: cam_ctrl

---
 rtl/cam_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cam_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl.sv
// Request sequencer in front of an external 16-entry CAM: lookup / insert-if-absent with FIFO replacement.
// Reserved key FF answers in 1 cycle, lookups/hits in 3, insert misses in 4; one request in flight, response held until rsp_ready.
module cam_ctrl #(
  parameter int NB_MEM    = 16,
  parameter int SIZE_ADDR = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [7:0]           req_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic                 rsp_new,
  output logic                 rsp_evict,
  output logic                 rsp_err,
  output logic [SIZE_ADDR-1:0] rsp_index,
  output logic [4:0]           occupancy,
  output logic                 full,
  output logic                 cam_enable,
  output logic                 cam_write,
  output logic [4:0]           cam_addr,
  output logic [7:0]           cam_data,
  input  logic [4:0]           cam_out,
  input  logic                 cam_found
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_CHECK, S_WRITE, S_RESP
  } state_t;

  localparam logic [SIZE_ADDR-1:0] LP_LAST = SIZE_ADDR'(NB_MEM - 1);
  localparam logic [4:0]           LP_FULL = 5'(NB_MEM);
  localparam logic [7:0]           LP_RSVD = 8'hFF;

  state_t               r_state;
  logic [SIZE_ADDR-1:0] r_init_cnt;
  logic [SIZE_ADDR-1:0] r_wr_ptr;
  logic [4:0]           r_occ;
  logic                 r_op;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic                 r_rsp_hit;
  logic                 r_rsp_new;
  logic                 r_rsp_evict;
  logic                 r_rsp_err;
  logic [SIZE_ADDR-1:0] r_rsp_index;
  logic                 r_cam_enable;
  logic                 r_cam_write;
  logic [4:0]           r_cam_addr;
  logic [7:0]           r_cam_data;
  logic                 w_unused;

  assign w_unused = cam_out[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_INIT;
      r_init_cnt   <= '0;
      r_wr_ptr     <= '0;
      r_occ        <= '0;
      r_op         <= 1'b0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_new    <= 1'b0;
      r_rsp_evict  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_index  <= '0;
      r_cam_enable <= 1'b0;
      r_cam_write  <= 1'b0;
      r_cam_addr   <= '0;
      r_cam_data   <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          // cam_enable low means the sweep has not started yet (first edge after reset)
          if (!r_cam_enable) begin
            r_cam_enable <= 1'b1;
            r_cam_write  <= 1'b1;
            r_cam_addr   <= '0;
            r_cam_data   <= LP_RSVD;
            r_init_cnt   <= '0;
          end else if (r_init_cnt == LP_LAST) begin
            r_cam_enable <= 1'b0;
            r_cam_write  <= 1'b0;
            r_cam_addr   <= '0;
            r_cam_data   <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_init_cnt <= r_init_cnt + SIZE_ADDR'(1);
            r_cam_addr <= 5'(r_init_cnt) + 5'd1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            r_op        <= req_op;
            if (req_key == LP_RSVD) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_hit   <= 1'b0;
              r_rsp_new   <= 1'b0;
              r_rsp_evict <= 1'b0;
              r_rsp_index <= '0;
              r_state     <= S_RESP;
            end else begin
              r_cam_enable <= 1'b1;
              r_cam_write  <= 1'b0;
              r_cam_data   <= req_key;
              r_state      <= S_LOOKUP;
            end
          end
        end
        S_LOOKUP: begin
          r_cam_enable <= 1'b0;
          r_state      <= S_CHECK;
        end
        S_CHECK: begin
          if (!r_op || cam_found) begin
            r_rsp_valid <= 1'b1;
            r_rsp_hit   <= cam_found;
            r_rsp_new   <= 1'b0;
            r_rsp_evict <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_index <= cam_found ? cam_out[SIZE_ADDR-1:0] : '0;
            r_cam_data  <= '0;
            r_state     <= S_RESP;
          end else begin
            r_cam_enable <= 1'b1;
            r_cam_write  <= 1'b1;
            r_cam_addr   <= 5'(r_wr_ptr);
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_cam_enable <= 1'b0;
          r_cam_write  <= 1'b0;
          r_cam_addr   <= '0;
          r_cam_data   <= '0;
          r_rsp_valid  <= 1'b1;
          r_rsp_hit    <= 1'b0;
          r_rsp_new    <= 1'b1;
          r_rsp_err    <= 1'b0;
          r_rsp_index  <= r_wr_ptr;
          // a full table overwrites the oldest slot, so occupancy saturates
          r_rsp_evict  <= (r_occ == LP_FULL);
          if (r_occ != LP_FULL) r_occ <= r_occ + 5'd1;
          r_wr_ptr     <= r_wr_ptr + SIZE_ADDR'(1);
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_hit    = r_rsp_hit;
  assign rsp_new    = r_rsp_new;
  assign rsp_evict  = r_rsp_evict;
  assign rsp_err    = r_rsp_err;
  assign rsp_index  = r_rsp_index;
  assign occupancy  = r_occ;
  assign full       = (r_occ == LP_FULL);
  assign cam_enable = r_cam_enable;
  assign cam_write  = r_cam_write;
  assign cam_addr   = r_cam_addr;
  assign cam_data   = r_cam_data;

endmodule

// File: tb/tb_cam_ctrl.sv
// Scoreboard bench for cam_ctrl with a behavioural 16-entry CAM (lookup result registered into the CHECK cycle).
module tb_cam_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_op = 1'b0;
  logic [7:0] req_key = 8'h00;
  logic       rsp_ready = 1'b1;
  logic       req_ready, rsp_valid, rsp_hit, rsp_new, rsp_evict, rsp_err, full;
  logic [3:0] rsp_index;
  logic [4:0] occupancy, cam_addr, cam_out;
  logic       cam_enable, cam_write, cam_found;
  logic [7:0] cam_data;

  cam_ctrl #(.NB_MEM(16), .SIZE_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_new(rsp_new), .rsp_evict(rsp_evict), .rsp_err(rsp_err),
    .rsp_index(rsp_index), .occupancy(occupancy), .full(full),
    .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr), .cam_data(cam_data),
    .cam_out(cam_out), .cam_found(cam_found)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hit, nw, ev, err;
    logic [3:0] idx;
    logic [4:0] occ;
    logic       full;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   hs_cnt = 0;

  // behavioural CAM: lowest matching index wins
  logic [7:0] mem [16];

  function automatic logic cam_hit_f(input logic [7:0] k);
    logic r = 1'b0;
    for (int i = 0; i < 16; i++) if (mem[i] === k) r = 1'b1;
    return r;
  endfunction

  function automatic logic [4:0] cam_idx_f(input logic [7:0] k);
    logic [4:0] r = 5'd0;
    for (int i = 15; i >= 0; i--) if (mem[i] === k) r = 5'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cam_enable && cam_write) mem[cam_addr[3:0]] <= cam_data;
    else if (cam_enable) begin
      cam_found <= cam_hit_f(cam_data);
      cam_out   <= cam_idx_f(cam_data);
    end
  end

  task automatic chk(input bit ok, input string nm, input string det);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", nm, det);
  endtask

  function automatic exp_t mk(input bit hit, input bit nw, input bit ev, input bit err,
                              input logic [3:0] idx, input logic [4:0] occ, input bit fl, input int lat);
    exp_t e;
    e.hit = hit; e.nw = nw; e.ev = ev; e.err = err;
    e.idx = idx; e.occ = occ; e.full = fl; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // monitor: latency on first valid cycle, stability while stalled, field compare on handshake
  logic        m_pv = 1'b0;
  logic        m_phs = 1'b0;
  logic [13:0] m_snap, m_cur, m_exp;
  exp_t        m_e;
  initial begin
    forever begin
      @(negedge clk); #1;
      m_cur = {rsp_hit, rsp_new, rsp_evict, rsp_err, rsp_index, occupancy, full};
      if (!rst_n || !rsp_valid) begin
        m_pv = 1'b0; m_phs = 1'b0;
      end else begin
        if (!m_pv || m_phs) begin
          if (q.size() == 0) chk(1'b0, "unexpected_rsp", $sformatf("got rsp fields %h with nothing pending", m_cur));
          else chk(cyc - q[0].acc + 1 == q[0].lat, "latency",
                   $sformatf("got %0d cycles, want %0d", cyc - q[0].acc + 1, q[0].lat));
        end else begin
          chk(m_cur == m_snap, "stable", $sformatf("got %h, held value %h", m_cur, m_snap));
        end
        if (rsp_ready) begin
          if (q.size() > 0) begin
            m_e = q.pop_front();
            m_exp = {m_e.hit, m_e.nw, m_e.ev, m_e.err, m_e.idx, m_e.occ, m_e.full};
            chk(m_cur == m_exp, "rsp",
                $sformatf("got hit/new/evict/err/idx/occ/full %b%b%b%b/%0d/%0d/%b want %b%b%b%b/%0d/%0d/%b",
                          rsp_hit, rsp_new, rsp_evict, rsp_err, rsp_index, occupancy, full,
                          m_e.hit, m_e.nw, m_e.ev, m_e.err, m_e.idx, m_e.occ, m_e.full));
          end
          hs_cnt++;
        end
        m_snap = m_cur; m_pv = 1'b1; m_phs = rsp_ready;
      end
    end
  end

  task automatic issue(input logic op, input logic [7:0] key, input bit push, input exp_t e);
    int   k = 0;
    exp_t x = e;
    @(negedge clk);
    while (!req_ready && k < 60) begin @(negedge clk); k++; end
    chk(req_ready, "req_ready_wait", $sformatf("got req_ready=%b after %0d cycles, want 1", req_ready, k));
    req_valid = 1'b1; req_op = op; req_key = key;
    if (push) begin x.acc = cyc + 1; q.push_back(x); end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic op, input logic [7:0] key, input exp_t e,
                        input bit exp_en, input bit exp_wr, input int hold);
    int n0 = hs_cnt;
    int k = 0;
    int held = 0;
    bit sen = 1'b0;
    bit swr = 1'b0;
    rsp_ready = (hold == 0);
    issue(op, key, 1'b1, e);
    while (hs_cnt == n0 && k < 40) begin
      sen |= cam_enable;
      swr |= cam_enable & cam_write;
      if (rsp_valid && !rsp_ready) begin
        held++;
        if (held > hold) rsp_ready = 1'b1;
      end
      @(negedge clk); k++;
    end
    chk(hs_cnt != n0, "rsp_timeout", $sformatf("key %h: got no handshake in %0d cycles, want one", key, k));
    chk(sen == exp_en && swr == exp_wr, "cam_use",
        $sformatf("key %h: got enable/write %b/%b, want %b/%b", key, sen, swr, exp_en, exp_wr));
    rsp_ready = 1'b1;
  endtask

  task automatic check_zero(input string nm);
    logic [33:0] v;
    v = {req_ready, rsp_valid, rsp_hit, rsp_new, rsp_evict, rsp_err, rsp_index, occupancy, full,
         cam_enable, cam_write, cam_addr, cam_data};
    chk(v == '0, nm, $sformatf("got outputs %h, want all zero", v));
  endtask

  task automatic check_init();
    int nw = 0;
    bit ok = 1'b1;
    for (int i = 0; i < 40 && !req_ready; i++) begin
      @(negedge clk);
      if (cam_enable && cam_write) begin
        if (cam_addr != 5'(nw) || cam_data != 8'hFF) ok = 1'b0;
        nw++;
      end
    end
    chk(ok && nw == 16, "init_sweep", $sformatf("got %0d writes (addr/data ok=%b), want 16 ordered FF writes", nw, ok));
    chk(req_ready && occupancy == 5'd0 && !full, "init_done",
        $sformatf("got ready/occ/full %b/%0d/%b, want 1/0/0", req_ready, occupancy, full));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int k;
    #12;
    check_zero("reset_outputs");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check_init();

    do_req(1'b1, 8'h3C, mk(0, 1, 0, 0, 4'd0, 5'd1, 0, 4), 1'b1, 1'b1, 0);
    do_req(1'b0, 8'h3C, mk(1, 0, 0, 0, 4'd0, 5'd1, 0, 3), 1'b1, 1'b0, 0);
    do_req(1'b1, 8'h3C, mk(1, 0, 0, 0, 4'd0, 5'd1, 0, 3), 1'b1, 1'b0, 0);
    do_req(1'b0, 8'hFF, mk(0, 0, 0, 1, 4'd0, 5'd1, 0, 1), 1'b0, 1'b0, 5);
    do_req(1'b0, 8'h77, mk(0, 0, 0, 0, 4'd0, 5'd1, 0, 3), 1'b1, 1'b0, 0);

    // reset while the controller sits in WRITE for a fresh insert
    issue(1'b1, 8'h55, 1'b0, mk(0, 0, 0, 0, 4'd0, 5'd0, 0, 0));
    k = 0;
    while (!(cam_enable && cam_write) && k < 10) begin @(negedge clk); k++; end
    chk(cam_enable && cam_write, "reach_write", $sformatf("got enable/write %b/%b, want 1/1", cam_enable, cam_write));
    #1 rst_n = 1'b0;
    #1 check_zero("midop_reset_outputs");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    check_init();

    do_req(1'b0, 8'h3C, mk(0, 0, 0, 0, 4'd0, 5'd0, 0, 3), 1'b1, 1'b0, 0);
    for (int i = 0; i < 16; i++)
      do_req(1'b1, 8'(i), mk(0, 1, 0, 0, 4'(i), 5'(i + 1), i == 15, 4), 1'b1, 1'b1, 0);
    do_req(1'b1, 8'h10, mk(0, 1, 1, 0, 4'd0, 5'd16, 1, 4), 1'b1, 1'b1, 0);
    do_req(1'b0, 8'h00, mk(0, 0, 0, 0, 4'd0, 5'd16, 1, 3), 1'b1, 1'b0, 0);
    do_req(1'b0, 8'h01, mk(1, 0, 0, 0, 4'd1, 5'd16, 1, 3), 1'b1, 1'b0, 0);
    do_req(1'b0, 8'h10, mk(1, 0, 0, 0, 4'd0, 5'd16, 1, 3), 1'b1, 1'b0, 0);
    do_req(1'b1, 8'h05, mk(1, 0, 0, 0, 4'd5, 5'd16, 1, 3), 1'b1, 1'b0, 0);
    do_req(1'b1, 8'hFF, mk(0, 0, 0, 1, 4'd0, 5'd16, 1, 1), 1'b0, 1'b0, 0);
    do_req(1'b1, 8'h20, mk(0, 1, 1, 0, 4'd1, 5'd16, 1, 4), 1'b1, 1'b1, 0);
    do_req(1'b0, 8'h01, mk(0, 0, 0, 0, 4'd0, 5'd16, 1, 3), 1'b1, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk(q.size() == 0, "queue_empty", $sformatf("got %0d pending responses, want 0", q.size()));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
